// File: rtl/rv2t_mem_arbiter.sv
// rv2t_mem_arbiter
// Shares the RV2T single memory port between instruction fetch (read-only)
// and load/store (read/write). Request pulses are captured into per-port
// pending slots, granted one at a time (round-robin on ties) and run against
// the memory enable/ack handshake. A watchdog aborts transactions whose ack
// never arrives.
module rv2t_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sync_reset,
    input  logic                    fetch_read_enable,
    input  logic [ADDR_WIDTH-1:0]   fetch_read_addr,
    output logic                    fetch_read_done,
    output logic [DATA_WIDTH-1:0]   fetch_read_data,
    input  logic                    data_read_enable,
    input  logic                    data_write_enable,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic [DATA_WIDTH/8-1:0] data_byte_enable,
    output logic                    data_done,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    mem_enable,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_timeout
);

    localparam int BE_W = DATA_WIDTH / 8;
    // A zero timeout disables the watchdog; keep the counter one bit wide then.
    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);
    localparam logic            WD_EN  = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    // Captured request slots
    logic                  fetch_pend_r;
    logic [ADDR_WIDTH-1:0] fetch_addr_r;
    logic                  data_pend_r;
    logic [ADDR_WIDTH-1:0] data_addr_r;
    logic [DATA_WIDTH-1:0] data_wdata_r;
    logic [BE_W-1:0]       data_be_r;
    logic                  data_write_r;

    // Transaction bookkeeping
    logic                  owner_r;
    logic                  owner_write_r;
    logic                  last_grant_r;
    logic [WD_W-1:0]       wd_r;

    // Registered outputs
    logic                  fetch_read_done_r;
    logic [DATA_WIDTH-1:0] fetch_read_data_r;
    logic                  data_done_r;
    logic [DATA_WIDTH-1:0] data_rdata_r;
    logic                  mem_enable_r;
    logic                  mem_write_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic [BE_W-1:0]       mem_be_r;
    logic                  mem_timeout_r;

    // Decode signals
    logic grant_s;
    logic grant_sel_s;
    logic ack_s;
    logic abort_s;
    logic wd_expire_s;
    logic fetch_accept_s;
    logic data_accept_s;

    assign wd_expire_s = WD_EN && (wd_r == WD_MAX);

    // A port is refused while its slot is full or its transaction is in flight.
    assign fetch_accept_s = fetch_read_enable && !fetch_pend_r &&
                            !((state_r == S_BUSY) && (owner_r == PORT_FETCH));
    assign data_accept_s  = (data_read_enable || data_write_enable) && !data_pend_r &&
                            !((state_r == S_BUSY) && (owner_r == PORT_DATA));

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else if (sync_reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (fetch_pend_r || data_pend_r) begin
                    state_nxt_s = S_BUSY;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mem_ack || wd_expire_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output decode: grant selection in idle, completion/abort in busy
    always_comb begin
        grant_s     = 1'b0;
        grant_sel_s = PORT_FETCH;
        ack_s       = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (fetch_pend_r && data_pend_r) begin
                    grant_s     = 1'b1;
                    grant_sel_s = (last_grant_r == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
                end else if (data_pend_r) begin
                    grant_s     = 1'b1;
                    grant_sel_s = PORT_DATA;
                end else if (fetch_pend_r) begin
                    grant_s     = 1'b1;
                    grant_sel_s = PORT_FETCH;
                end else begin
                    grant_s     = 1'b0;
                    grant_sel_s = PORT_FETCH;
                end
            end
            S_BUSY: begin
                // An ack in the final watchdog cycle wins over the abort.
                if (mem_ack) begin
                    ack_s = 1'b1;
                end else if (wd_expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    ack_s   = 1'b0;
                    abort_s = 1'b0;
                end
            end
            default: begin
                grant_s = 1'b0;
            end
        endcase
    end

    // Fetch request slot: capture on accepted pulse, release on grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pend_r <= 1'b0;
            fetch_addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (sync_reset) begin
            fetch_pend_r <= 1'b0;
            fetch_addr_r <= {ADDR_WIDTH{1'b0}};
        end else if (fetch_accept_s) begin
            fetch_pend_r <= 1'b1;
            fetch_addr_r <= fetch_read_addr;
        end else if (grant_s && (grant_sel_s == PORT_FETCH)) begin
            fetch_pend_r <= 1'b0;
        end
    end

    // Load/store request slot: write wins when both enables pulse together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_pend_r  <= 1'b0;
            data_addr_r  <= {ADDR_WIDTH{1'b0}};
            data_wdata_r <= {DATA_WIDTH{1'b0}};
            data_be_r    <= {BE_W{1'b0}};
            data_write_r <= 1'b0;
        end else if (sync_reset) begin
            data_pend_r  <= 1'b0;
            data_addr_r  <= {ADDR_WIDTH{1'b0}};
            data_wdata_r <= {DATA_WIDTH{1'b0}};
            data_be_r    <= {BE_W{1'b0}};
            data_write_r <= 1'b0;
        end else if (data_accept_s) begin
            data_pend_r  <= 1'b1;
            data_addr_r  <= data_addr;
            data_wdata_r <= data_wdata;
            data_be_r    <= data_byte_enable;
            data_write_r <= data_write_enable;
        end else if (grant_s && (grant_sel_s == PORT_DATA)) begin
            data_pend_r <= 1'b0;
        end
    end

    // Memory request outputs: one-cycle enable, fields held until next grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_enable_r  <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_addr_r    <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r   <= {DATA_WIDTH{1'b0}};
            mem_be_r      <= {BE_W{1'b0}};
            owner_r       <= PORT_FETCH;
            owner_write_r <= 1'b0;
        end else if (sync_reset) begin
            mem_enable_r  <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_addr_r    <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r   <= {DATA_WIDTH{1'b0}};
            mem_be_r      <= {BE_W{1'b0}};
            owner_r       <= PORT_FETCH;
            owner_write_r <= 1'b0;
        end else if (grant_s) begin
            mem_enable_r <= 1'b1;
            owner_r      <= grant_sel_s;
            if (grant_sel_s == PORT_DATA) begin
                mem_write_r   <= data_write_r;
                mem_addr_r    <= data_addr_r;
                mem_wdata_r   <= data_wdata_r;
                mem_be_r      <= data_be_r;
                owner_write_r <= data_write_r;
            end else begin
                mem_write_r   <= 1'b0;
                mem_addr_r    <= fetch_addr_r;
                mem_wdata_r   <= {DATA_WIDTH{1'b0}};
                mem_be_r      <= {BE_W{1'b0}};
                owner_write_r <= 1'b0;
            end
        end else begin
            mem_enable_r <= 1'b0;
        end
    end

    // Watchdog: cleared at issue, counts busy cycles and saturates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_r <= {WD_W{1'b0}};
        end else if (sync_reset) begin
            wd_r <= {WD_W{1'b0}};
        end else if (grant_s) begin
            wd_r <= {WD_W{1'b0}};
        end else if ((state_r == S_BUSY) && (wd_r != WD_MAX)) begin
            wd_r <= wd_r + WD_ONE;
        end
    end

    // Completion: done pulses, returned data, abort flag and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_read_done_r <= 1'b0;
            fetch_read_data_r <= {DATA_WIDTH{1'b0}};
            data_done_r       <= 1'b0;
            data_rdata_r      <= {DATA_WIDTH{1'b0}};
            mem_timeout_r     <= 1'b0;
            last_grant_r      <= PORT_FETCH;
        end else if (sync_reset) begin
            fetch_read_done_r <= 1'b0;
            fetch_read_data_r <= {DATA_WIDTH{1'b0}};
            data_done_r       <= 1'b0;
            data_rdata_r      <= {DATA_WIDTH{1'b0}};
            mem_timeout_r     <= 1'b0;
            last_grant_r      <= PORT_FETCH;
        end else begin
            fetch_read_done_r <= 1'b0;
            data_done_r       <= 1'b0;
            mem_timeout_r     <= abort_s;
            if (ack_s || abort_s) begin
                last_grant_r <= owner_r;
                if (owner_r == PORT_DATA) begin
                    data_done_r  <= 1'b1;
                    data_rdata_r <= (ack_s && !owner_write_r) ? mem_rdata : {DATA_WIDTH{1'b0}};
                end else begin
                    fetch_read_done_r <= 1'b1;
                    fetch_read_data_r <= ack_s ? mem_rdata : {DATA_WIDTH{1'b0}};
                end
            end
        end
    end

    assign fetch_read_done = fetch_read_done_r;
    assign fetch_read_data = fetch_read_data_r;
    assign data_done       = data_done_r;
    assign data_rdata      = data_rdata_r;
    assign mem_enable      = mem_enable_r;
    assign mem_write       = mem_write_r;
    assign mem_addr        = mem_addr_r;
    assign mem_wdata       = mem_wdata_r;
    assign mem_byte_enable = mem_be_r;
    assign mem_timeout     = mem_timeout_r;

endmodule

// File: tb/tb_rv2t_mem_arbiter.sv
// Directed bench for rv2t_mem_arbiter (TIMEOUT_CYCLES = 4).
module tb_rv2t_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sync_reset;
    logic        fetch_read_enable;
    logic [31:0] fetch_read_addr;
    logic        fetch_read_done;
    logic [31:0] fetch_read_data;
    logic        data_read_enable;
    logic        data_write_enable;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_byte_enable;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        mem_enable;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_timeout;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    rv2t_mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sync_reset(sync_reset),
        .fetch_read_enable(fetch_read_enable),
        .fetch_read_addr(fetch_read_addr),
        .fetch_read_done(fetch_read_done),
        .fetch_read_data(fetch_read_data),
        .data_read_enable(data_read_enable),
        .data_write_enable(data_write_enable),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_byte_enable(data_byte_enable),
        .data_done(data_done),
        .data_rdata(data_rdata),
        .mem_enable(mem_enable),
        .mem_write(mem_write),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Advance one cycle; land 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        sync_reset        = 1'b0;
        fetch_read_enable = 1'b0;
        fetch_read_addr   = 32'h0;
        data_read_enable  = 1'b0;
        data_write_enable = 1'b0;
        data_addr         = 32'h0;
        data_wdata        = 32'h0;
        data_byte_enable  = 4'h0;
        mem_ack           = 1'b0;
        mem_rdata         = 32'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Memory model: ack lat cycles after the current (enable) cycle; returns in the done cycle
    task automatic serve(input int lat, input logic [31:0] rd);
        for (int i = 0; i < lat; i++) step();
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    // Bounded wait for mem_enable
    task automatic wait_enable(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (mem_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #3;
        chk_cnt++; if ({fetch_read_done, fetch_read_data, data_done, data_rdata, mem_enable, mem_write, mem_addr, mem_wdata, mem_byte_enable, mem_timeout} !== 136'h0) $display("FAIL reset_outputs: got nonzero output, fetch_done=%b mem_en=%b mem_addr=%h", fetch_read_done, mem_enable, mem_addr); else pass_cnt++;
        step();
        reset_n = 1'b1;
        step();
        step();
        chk_cnt++; if (mem_enable !== 1'b0) $display("FAIL reset_idle: mem_enable=%b want 0", mem_enable); else pass_cnt++;
    endtask

    task automatic test_single_fetch();
        apply_reset();
        fetch_read_enable = 1'b1;
        fetch_read_addr   = 32'h100;
        step();
        fetch_read_enable = 1'b0;
        chk_cnt++; if (mem_enable !== 1'b0) $display("FAIL fetch_t1_enable: got %b want 0", mem_enable); else pass_cnt++;
        step();
        chk_cnt++; if (mem_enable !== 1'b1) $display("FAIL fetch_t2_enable: got %b want 1", mem_enable); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 32'h100) $display("FAIL fetch_addr: got %h want %h", mem_addr, 32'h100); else pass_cnt++;
        chk_cnt++; if (mem_write !== 1'b0) $display("FAIL fetch_write: got %b want 0", mem_write); else pass_cnt++;
        step();
        chk_cnt++; if (mem_enable !== 1'b0) $display("FAIL fetch_enable_pulse: got %b want 0", mem_enable); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 32'h100) $display("FAIL fetch_addr_hold: got %h want %h", mem_addr, 32'h100); else pass_cnt++;
        serve(2, 32'h00000013);
        chk_cnt++; if (fetch_read_done !== 1'b1) $display("FAIL fetch_done: got %b want 1", fetch_read_done); else pass_cnt++;
        chk_cnt++; if (fetch_read_data !== 32'h00000013) $display("FAIL fetch_data: got %h want %h", fetch_read_data, 32'h13); else pass_cnt++;
        step();
        chk_cnt++; if (fetch_read_done !== 1'b0) $display("FAIL fetch_done_pulse: got %b want 0", fetch_read_done); else pass_cnt++;
        chk_cnt++; if (fetch_read_data !== 32'h00000013) $display("FAIL fetch_data_hold: got %h want %h", fetch_read_data, 32'h13); else pass_cnt++;
    endtask

    task automatic test_tie();
        apply_reset();
        fetch_read_enable = 1'b1;
        fetch_read_addr   = 32'h200;
        data_write_enable = 1'b1;
        data_addr         = 32'h400;
        data_wdata        = 32'hDEADBEEF;
        data_byte_enable  = 4'hF;
        step();
        fetch_read_enable = 1'b0;
        data_write_enable = 1'b0;
        step();
        chk_cnt++; if (mem_enable !== 1'b1) $display("FAIL tie_enable: got %b want 1", mem_enable); else pass_cnt++;
        chk_cnt++; if (mem_write !== 1'b1) $display("FAIL tie_first_write: got %b want 1", mem_write); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 32'h400) $display("FAIL tie_first_addr: got %h want %h", mem_addr, 32'h400); else pass_cnt++;
        chk_cnt++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL tie_wdata: got %h want %h", mem_wdata, 32'hDEADBEEF); else pass_cnt++;
        chk_cnt++; if (mem_byte_enable !== 4'hF) $display("FAIL tie_be: got %h want %h", mem_byte_enable, 4'hF); else pass_cnt++;
        serve(1, 32'h12345678);
        chk_cnt++; if (data_done !== 1'b1) $display("FAIL store_done: got %b want 1", data_done); else pass_cnt++;
        chk_cnt++; if (data_rdata !== 32'h0) $display("FAIL store_rdata_zero: got %h want 0", data_rdata); else pass_cnt++;
        chk_cnt++; if (mem_enable !== 1'b0) $display("FAIL tie_no_early_issue: got %b want 0", mem_enable); else pass_cnt++;
        // Lone store requested in the done cycle so the next tie follows a data grant
        data_write_enable = 1'b1;
        data_addr         = 32'h404;
        step();
        data_write_enable = 1'b0;
        chk_cnt++; if ((mem_enable !== 1'b1) || (mem_addr !== 32'h200) || (mem_write !== 1'b0)) $display("FAIL tie_second_fetch: en=%b addr=%h wr=%b want 1/200/0", mem_enable, mem_addr, mem_write); else pass_cnt++;
        serve(1, 32'h00000093);
        chk_cnt++; if ((fetch_read_done !== 1'b1) || (fetch_read_data !== 32'h93)) $display("FAIL tie_fetch_done: done=%b data=%h want 1/00000093", fetch_read_done, fetch_read_data); else pass_cnt++;
        step();
        chk_cnt++; if ((mem_enable !== 1'b1) || (mem_addr !== 32'h404)) $display("FAIL lone_store_issue: en=%b addr=%h want 1/404", mem_enable, mem_addr); else pass_cnt++;
        serve(1, 32'h0);
        fetch_read_enable = 1'b1;
        fetch_read_addr   = 32'h208;
        data_read_enable  = 1'b1;
        data_addr         = 32'h408;
        step();
        fetch_read_enable = 1'b0;
        data_read_enable  = 1'b0;
        step();
        chk_cnt++; if ((mem_enable !== 1'b1) || (mem_addr !== 32'h208)) $display("FAIL tie2_fetch_wins: en=%b addr=%h want 1/208", mem_enable, mem_addr); else pass_cnt++;
        serve(1, 32'h1);
        step();
        chk_cnt++; if ((mem_enable !== 1'b1) || (mem_addr !== 32'h408)) $display("FAIL tie2_load_next: en=%b addr=%h want 1/408", mem_enable, mem_addr); else pass_cnt++;
        serve(1, 32'h2);
        step();
    endtask

    task automatic test_back_to_back();
        int  fetch_grants;
        int  data_grants;
        int  last_e;
        bit  ok;
        logic [3:0] want;
        fetch_grants = 0;
        data_grants  = 0;
        last_e       = 0;
        apply_reset();
        fetch_read_enable = 1'b1;
        fetch_read_addr   = 32'h1000;
        data_read_enable  = 1'b1;
        data_addr         = 32'h2000;
        step();
        fetch_read_enable = 1'b0;
        data_read_enable  = 1'b0;
        for (int r = 0; r < 8; r++) begin
            wait_enable(10, ok);
            chk_cnt++; if (!ok) $display("FAIL rr_enable_timeout: round %0d got no mem_enable within 10 cycles", r); else pass_cnt++;
            if (r > 0) begin
                chk_cnt++; if ((cyc - last_e) !== 3) $display("FAIL rr_throughput: round %0d gap %0d want 3", r, cyc - last_e); else pass_cnt++;
            end
            last_e = cyc;
            want = ((r % 2) == 0) ? 4'h2 : 4'h1;
            chk_cnt++; if (mem_addr[15:12] !== want) $display("FAIL rr_owner: round %0d got port %h want %h", r, mem_addr[15:12], want); else pass_cnt++;
            if (mem_addr[15:12] === 4'h1) fetch_grants++;
            if (mem_addr[15:12] === 4'h2) data_grants++;
            serve(1, 32'h100 + r);
            if (want == 4'h2) begin
                chk_cnt++; if ((data_done !== 1'b1) || (data_rdata !== (32'h100 + r))) $display("FAIL rr_data_done: round %0d done=%b data=%h", r, data_done, data_rdata); else pass_cnt++;
            end else begin
                chk_cnt++; if ((fetch_read_done !== 1'b1) || (fetch_read_data !== (32'h100 + r))) $display("FAIL rr_fetch_done: round %0d done=%b data=%h", r, fetch_read_done, fetch_read_data); else pass_cnt++;
            end
            if (r < 6) begin
                if (want == 4'h2) begin
                    data_read_enable = 1'b1;
                    data_addr        = 32'h2000 + (r + 2) * 4;
                end else begin
                    fetch_read_enable = 1'b1;
                    fetch_read_addr   = 32'h1000 + (r + 2) * 4;
                end
            end
            step();
            fetch_read_enable = 1'b0;
            data_read_enable  = 1'b0;
        end
        chk_cnt++; if ((fetch_grants !== 4) || (data_grants !== 4)) $display("FAIL rr_balance: fetch=%0d data=%0d want 4/4", fetch_grants, data_grants); else pass_cnt++;
    endtask

    task automatic test_duplicate();
        int extra;
        extra = 0;
        apply_reset();
        data_write_enable = 1'b1;
        data_addr         = 32'h500;
        step();
        data_write_enable = 1'b0;
        step();
        // Store in flight: fetch 0x200 fills the slot, 0x300 must be dropped
        fetch_read_enable = 1'b1;
        fetch_read_addr   = 32'h200;
        step();
        fetch_read_addr   = 32'h300;
        step();
        fetch_read_enable = 1'b0;
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk_cnt++; if (data_done !== 1'b1) $display("FAIL dup_store_done: got %b want 1", data_done); else pass_cnt++;
        step();
        chk_cnt++; if ((mem_enable !== 1'b1) || (mem_addr !== 32'h200)) $display("FAIL dup_issue: en=%b addr=%h want 1/200", mem_enable, mem_addr); else pass_cnt++;
        serve(1, 32'hABCD0000);
        chk_cnt++; if ((fetch_read_done !== 1'b1) || (fetch_read_data !== 32'hABCD0000)) $display("FAIL dup_done: done=%b data=%h", fetch_read_done, fetch_read_data); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            if ((mem_enable === 1'b1) || (fetch_read_done === 1'b1)) extra++;
        end
        chk_cnt++; if (extra !== 0) $display("FAIL dup_dropped: got %0d extra enable/done cycles want 0", extra); else pass_cnt++;
    endtask

    task automatic test_timeout();
        apply_reset();
        data_read_enable = 1'b1;
        data_addr        = 32'h600;
        step();
        data_read_enable = 1'b0;
        step();
        serve(2, 32'hCAFEF00D);
        chk_cnt++; if ((data_done !== 1'b1) || (data_rdata !== 32'hCAFEF00D)) $display("FAIL to_load1: done=%b data=%h", data_done, data_rdata); else pass_cnt++;
        data_read_enable = 1'b1;
        data_addr        = 32'h604;
        step();
        data_read_enable = 1'b0;
        step();
        chk_cnt++; if ((mem_enable !== 1'b1) || (mem_addr !== 32'h604)) $display("FAIL to_issue: en=%b addr=%h want 1/604", mem_enable, mem_addr); else pass_cnt++;
        fetch_read_enable = 1'b1;
        fetch_read_addr   = 32'h700;
        step();
        fetch_read_enable = 1'b0;
        step();
        step();
        step();
        chk_cnt++; if ((data_done !== 1'b0) || (mem_timeout !== 1'b0)) $display("FAIL to_early: done=%b timeout=%b at E+4 want 0/0", data_done, mem_timeout); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 32'h604) $display("FAIL to_addr_hold: got %h want 604", mem_addr); else pass_cnt++;
        step();
        chk_cnt++; if ((data_done !== 1'b1) || (mem_timeout !== 1'b1)) $display("FAIL to_abort: done=%b timeout=%b at E+5 want 1/1", data_done, mem_timeout); else pass_cnt++;
        chk_cnt++; if (data_rdata !== 32'h0) $display("FAIL to_rdata_zero: got %h want 0", data_rdata); else pass_cnt++;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk_cnt++; if ((data_done !== 1'b0) || (mem_timeout !== 1'b0) || (fetch_read_done !== 1'b0)) $display("FAIL to_late_ack: ddone=%b tmo=%b fdone=%b want 0/0/0", data_done, mem_timeout, fetch_read_done); else pass_cnt++;
        chk_cnt++; if ((mem_enable !== 1'b1) || (mem_addr !== 32'h700)) $display("FAIL to_fetch_issue: en=%b addr=%h want 1/700", mem_enable, mem_addr); else pass_cnt++;
        // Ack in the last watchdog cycle completes normally
        serve(4, 32'h00000077);
        chk_cnt++; if ((fetch_read_done !== 1'b1) || (fetch_read_data !== 32'h77) || (mem_timeout !== 1'b0)) $display("FAIL to_boundary_ack: done=%b data=%h tmo=%b want 1/77/0", fetch_read_done, fetch_read_data, mem_timeout); else pass_cnt++;
    endtask

    task automatic test_reset_mid(input bit use_sync);
        int stray;
        stray = 0;
        apply_reset();
        fetch_read_enable = 1'b1;
        fetch_read_addr   = 32'h800;
        step();
        fetch_read_enable = 1'b0;
        step();
        data_write_enable = 1'b1;
        data_addr         = 32'h900;
        data_wdata        = 32'h11112222;
        data_byte_enable  = 4'h3;
        step();
        data_write_enable = 1'b0;
        if (use_sync) begin
            sync_reset = 1'b1;
            step();
            sync_reset = 1'b0;
        end else begin
            #2;
            reset_n = 1'b0;
            #1;
            reset_n = 1'b1;
        end
        chk_cnt++; if ({fetch_read_done, fetch_read_data, data_done, data_rdata, mem_enable, mem_write, mem_addr, mem_wdata, mem_byte_enable, mem_timeout} !== 136'h0) $display("FAIL mid_reset_outputs(sync=%0d): nonzero output addr=%h en=%b", use_sync, mem_addr, mem_enable); else pass_cnt++;
        if (!use_sync) step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk_cnt++; if ((fetch_read_done !== 1'b0) || (data_done !== 1'b0)) $display("FAIL mid_reset_ack_ignored(sync=%0d): fdone=%b ddone=%b want 0/0", use_sync, fetch_read_done, data_done); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            if (mem_enable === 1'b1) stray++;
            step();
        end
        chk_cnt++; if (stray !== 0) $display("FAIL mid_reset_pending_cleared(sync=%0d): got %0d issues want 0", use_sync, stray); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie();
        test_back_to_back();
        test_duplicate();
        test_timeout();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/rv2t_mem_arbiter.md
# rv2t_mem_arbiter

Two-requester arbiter that shares the RV2T core's single memory port between the instruction-fetch unit (read-only) and the load/store unit (read/write). It captures single-cycle request pulses from each side, grants the port using round-robin on ties, runs one transaction at a time against the memory controller's enable/ack handshake, and returns a one-cycle done pulse with read data to the owning requester. A watchdog aborts transactions whose ack never arrives.

## Interface
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before aborting; 0 disables the watchdog

Ports (fixed: one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous clear of FSM and pending requests
- fetch_read_enable  in  1  fetch read request pulse
- fetch_read_addr  in  ADDR_WIDTH  fetch address, valid with pulse
- fetch_read_done  out  1  fetch completion pulse
- fetch_read_data  out  DATA_WIDTH  fetch read data, valid with done
- data_read_enable  in  1  load request pulse
- data_write_enable  in  1  store request pulse
- data_addr  in  ADDR_WIDTH  load/store address
- data_wdata  in  DATA_WIDTH  store data
- data_byte_enable  in  DATA_WIDTH/8  store byte lanes
- data_done  out  1  load/store completion pulse
- data_rdata  out  DATA_WIDTH  load data, valid with data_done
- mem_enable  out  1  memory transaction start pulse
- mem_write  out  1  1 = write, 0 = read; valid with mem_enable
- mem_addr, mem_wdata, mem_byte_enable  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  transaction fields, held until ack or abort
- mem_ack  in  1  memory completion pulse
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
- mem_timeout  out  1  abort pulse from the watchdog

## Operation
- Capture: a request pulse sets that port's pending flag and latches its fields (fetch: addr; data: addr, wdata, byte_enable, write = data_write_enable). Simultaneous data_read_enable and data_write_enable: write wins.
- A request from a port whose pending flag is set or whose transaction is in flight is dropped (no state change). A new request in the same cycle as that port's done pulse is accepted.
- FSM states: S_IDLE, S_BUSY.
- S_IDLE: if any pending flag is set, grant: only one pending -> that one; both pending -> the port not granted last (last_grant resets to fetch, so data wins the first tie). On grant: clear its pending flag, drive mem_* fields, pulse mem_enable, load watchdog, go S_BUSY.
- S_BUSY: on mem_ack -> register mem_rdata into the owner's data output (fetch_read_data or data_rdata; write acks leave data_rdata = 0), pulse owner's done, update last_grant, go S_IDLE. Watchdog reaches TIMEOUT_CYCLES without ack -> owner's done pulses with data = 0, mem_timeout pulses, go S_IDLE.
- mem_ack in S_IDLE is ignored.
- sync_reset: pending flags cleared, state S_IDLE, outputs as after reset; in-flight transaction dropped, its later ack ignored.
- Watchdog counter is ceil(log2(TIMEOUT_CYCLES+1)) bits, counts cycles in S_BUSY, saturates; no wrap.

## Timing
- Reset values: all outputs 0; state S_IDLE; pending flags 0; last_grant = fetch.
- Request pulse at cycle T -> pending at T+1 -> mem_enable high at T+2 if port free (minimum issue latency 2).
- mem_enable high exactly one cycle; mem_addr/mem_write/mem_wdata/mem_byte_enable stable from issue until the cycle after ack/abort.
- mem_ack at cycle A -> done pulse and data at A+1; state S_IDLE at A+1; next grant's mem_enable at A+2 earliest.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- Timeout: no ack in the TIMEOUT_CYCLES cycles following mem_enable -> done and mem_timeout at the next cycle; an ack in that same final cycle takes precedence (normal completion, no mem_timeout).
- Done outputs are single-cycle pulses; data outputs hold until the next completion for that port.

## Test plan
- Single fetch: fetch_read_enable at T, addr 0x100; memory acks 3 cycles after mem_enable with 0x00000013 -> mem_enable at T+2, mem_addr 0x100, mem_write 0; fetch_read_done at ack+1 with data 0x00000013.
- Simultaneous tie after reset: fetch (0x200) and store (addr 0x400, wdata 0xDEADBEEF, be 0xF) same cycle -> store issued first, fetch issued after its done; next tie goes to fetch.
- Continuous contention: both ports re-request on every done for 8 rounds -> grants strictly alternate, 4 each per 8 transactions.
- Duplicate request: second fetch pulse (addr 0x300) while fetch 0x200 pending -> only 0x200 issued; one fetch_read_done.
- Timeout with TIMEOUT_CYCLES = 4: load never acked -> data_done and mem_timeout pulse 5 cycles after mem_enable, data_rdata 0; late ack ignored; pending fetch then issues.
- reset_n asserted mid-transaction, then sync_reset mid-transaction in a second run -> all outputs 0, pending cleared, subsequent ack produces no done pulse.
